// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-side definitions: machine width, reset PC default, canonical NOP,
// the {pc, instr} packet handed to decode and the fetch buffer occupancy encoding.
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned CNT_W     = 2;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] I_NOP            = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Encoded so the state value is also the entry count.
  typedef enum logic [CNT_W-1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Program ROM is word addressed; low byte-offset bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: program_rom address/data, execute redirect, decode handshake.
//  master : fetch unit side (drives addr_bus, instr_*, misalign_err)
//  slave  : environment side (program_rom, execute, decode)
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic            fetch_en;
  logic [XLEN-1:0] addr_bus;
  logic [XLEN-1:0] data_bus;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            misalign_err;

  modport master (
    input  fetch_en, data_bus, redirect_valid, redirect_pc, instr_ready,
    output addr_bus, instr_valid, instr, instr_pc, misalign_err
  );

  modport slave (
    output fetch_en, data_bus, redirect_valid, redirect_pc, instr_ready,
    input  addr_bus, instr_valid, instr, instr_pc, misalign_err
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of fetch packets with flush.
//  clk, rst      : clock, synchronous active-high reset
//  push/push_pkt : enqueue request and payload (caller guarantees room or a same-cycle pop)
//  pop           : dequeue head; ignored when empty
//  flush         : discard all entries; overrides push/pop
//  head_pkt      : registered head entry, holds its value while empty
//  head_valid    : registered, head_pkt holds a live entry
//  count         : registered occupancy 0..2
module fetch_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_pkt_t       push_pkt,
  input  logic             pop,
  input  logic             flush,
  output fetch_pkt_t       head_pkt,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  buf_state_e state_q, state_nx;
  fetch_pkt_t head_q, head_nx;
  fetch_pkt_t tail_q, tail_nx;
  logic       valid_q, valid_nx;
  logic       do_pop;

  // Occupancy state, head/tail storage and registered valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_nx;
      head_q  <= head_nx;
      tail_q  <= tail_nx;
      valid_q <= valid_nx;
    end
  end

  // Next occupancy and data movement; the tail shifts into the head on a pop.
  always_comb begin
    state_nx = state_q;
    head_nx  = head_q;
    tail_nx  = tail_q;
    do_pop   = pop & (state_q != BUF_EMPTY);

    if (flush) begin
      state_nx = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (push) begin
            head_nx  = push_pkt;
            state_nx = BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push, do_pop})
            2'b10: begin
              tail_nx  = push_pkt;
              state_nx = BUF_FULL;
            end
            2'b01:   state_nx = BUF_EMPTY;
            2'b11:   head_nx  = push_pkt;
            default: state_nx = BUF_ONE;
          endcase
        end
        BUF_FULL: begin
          if (do_pop) begin
            head_nx  = tail_q;
            state_nx = BUF_ONE;
            if (push) begin
              tail_nx  = push_pkt;
              state_nx = BUF_FULL;
            end
          end
        end
        default: state_nx = BUF_EMPTY;
      endcase
    end

    valid_nx = (state_nx != BUF_EMPTY);
  end

  assign head_pkt   = head_q;
  assign head_valid = valid_q;
  assign count      = state_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, program_rom fetch and branch/jump redirect feeding decode.
//  clk, rst : clock, synchronous active-high reset
//  bus      : instr_fetch_unit_if.master
//             fetch_en, data_bus, redirect_valid/redirect_pc, instr_ready in;
//             addr_bus (= pc register), instr_valid/instr/instr_pc, misalign_err out
// The ROM word for the current pc is captured together with the pc into the fetch
// buffer; the buffer head is what decode sees.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned     BUF_DEPTH = instr_fetch_unit_pkg::BUF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  logic [XLEN-1:0]  pc_q, pc_nx;
  logic             misalign_q, misalign_nx;
  logic             pop_c, push_c;
  logic [CNT_W-1:0] count;
  logic             head_valid;
  fetch_pkt_t       head_pkt;
  fetch_pkt_t       push_pkt;

  // Push whenever fetch is allowed and there is (or will be) room; a redirect
  // cycle never pushes because the word at the old pc is on the wrong path.
  always_comb begin
    pop_c    = head_valid & bus.instr_ready;
    push_c   = bus.fetch_en & ~bus.redirect_valid &
               ((count < CNT_W'(BUF_DEPTH)) | pop_c);
    push_pkt = '{pc: pc_q, instr: bus.data_bus};
  end

  // Next pc: redirect target wins, otherwise advance one word per push (wraps mod 2^32).
  always_comb begin
    pc_nx       = pc_q;
    misalign_nx = 1'b0;
    if (bus.redirect_valid) begin
      pc_nx       = word_align(bus.redirect_pc);
      misalign_nx = |bus.redirect_pc[1:0];
    end else if (push_c) begin
      pc_nx = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_nx;
      misalign_q <= misalign_nx;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push_c),
    .push_pkt   (push_pkt),
    .pop        (pop_c),
    .flush      (bus.redirect_valid),
    .head_pkt   (head_pkt),
    .head_valid (head_valid),
    .count      (count)
  );

  assign bus.addr_bus     = word_align(pc_q);
  assign bus.instr_valid  = head_valid;
  assign bus.instr        = head_pkt.instr;
  assign bus.instr_pc     = head_pkt.pc;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by a
// random ready/redirect/fetch_en/reset phase, all scored against a reference
// PC + buffer model that queues expected packets as stimulus is applied.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Program ROM: two real instructions, a NOP at 0x10, address-tagged filler elsewhere.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h0030_6093;
      30'd1:   return 32'h0040_A113;
      30'd4:   return I_NOP;
      default: return {16'hC0DE, a[17:2]};
    endcase
  endfunction

  always_comb ifc.data_bus = rom_word(ifc.addr_bus);

  int          n_chk  = 0;
  int          n_fail = 0;
  fetch_pkt_t  sb[$];
  logic [31:0] m_pc;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model advanced by the inputs about to be clocked in.
  task automatic model(input logic r, input logic fe, input logic rd,
                       input logic rv, input logic [31:0] rp);
    bit pop, full_before;
    if (r) begin
      sb.delete();
      m_pc  = 32'h0;
      m_err = 1'b0;
    end else if (rv) begin
      sb.delete();
      m_pc  = {rp[31:2], 2'b00};
      m_err = |rp[1:0];
    end else begin
      pop         = (sb.size() > 0) && rd;
      full_before = (sb.size() >= 2);
      if (pop) void'(sb.pop_front());
      if (fe && (!full_before || pop)) begin
        sb.push_back('{pc: m_pc, instr: rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_err = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("sb_valid", 32'(ifc.instr_valid), 32'(sb.size() != 0));
    chk("sb_addr", ifc.addr_bus, m_pc);
    chk("sb_misalign", 32'(ifc.misalign_err), 32'(m_err));
    if (sb.size() != 0) begin
      chk("sb_instr_pc", ifc.instr_pc, sb[0].pc);
      chk("sb_instr", ifc.instr, sb[0].instr);
    end
  endtask

  task automatic cyc(input logic r, input logic fe, input logic rd,
                     input logic rv, input logic [31:0] rp);
    rst                = r;
    ifc.fetch_en       = fe;
    ifc.instr_ready    = rd;
    ifc.redirect_valid = rv;
    ifc.redirect_pc    = rp;
    model(r, fe, rd, rv, rp);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    logic        r, fe, rd, rv;
    logic [31:0] rp;

    rst = 1'b1; ifc.fetch_en = 1'b1; ifc.instr_ready = 1'b1;
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = 32'h0;

    // 1: reset state, then in-order stream at one instruction per cycle
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    chk("rst_valid", 32'(ifc.instr_valid), 32'd0);
    chk("rst_instr", ifc.instr, 32'h0);
    chk("rst_instr_pc", ifc.instr_pc, 32'h0);
    chk("rst_addr", ifc.addr_bus, 32'h0);
    chk("rst_misalign", 32'(ifc.misalign_err), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("t1_c1_instr", ifc.instr, 32'h0030_6093);
    chk("t1_c1_pc", ifc.instr_pc, 32'h0);
    cyc(0, 1, 1, 0, 0);
    chk("t1_c2_instr", ifc.instr, 32'h0040_A113);
    chk("t1_c2_pc", ifc.instr_pc, 32'h4);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
    chk("t1_c6_pc", ifc.instr_pc, 32'h14);

    // 2: decode stalls, buffer saturates at two entries, then drains in order
    cyc(1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
    chk("t2_addr_hold", ifc.addr_bus, 32'h8);
    chk("t2_head_pc", ifc.instr_pc, 32'h0);
    cyc(0, 1, 1, 0, 0);
    chk("t2_pc4", ifc.instr_pc, 32'h4);
    cyc(0, 1, 1, 0, 0);
    chk("t2_pc8", ifc.instr_pc, 32'h8);
    cyc(0, 1, 1, 0, 0);
    chk("t2_pc12", ifc.instr_pc, 32'hC);

    // 3: redirect with a full buffer and a pending pop
    cyc(0, 1, 1, 1, 32'h10);
    chk("t3_valid_bubble", 32'(ifc.instr_valid), 32'd0);
    cyc(0, 1, 1, 0, 0);
    chk("t3_valid", 32'(ifc.instr_valid), 32'd1);
    chk("t3_pc", ifc.instr_pc, 32'h10);
    chk("t3_instr_nop", ifc.instr, I_NOP);

    // 4: misaligned redirect target
    cyc(0, 1, 1, 1, 32'h6);
    chk("t4_misalign_hi", 32'(ifc.misalign_err), 32'd1);
    chk("t4_addr", ifc.addr_bus, 32'h4);
    cyc(0, 1, 1, 0, 0);
    chk("t4_misalign_lo", 32'(ifc.misalign_err), 32'd0);
    chk("t4_pc", ifc.instr_pc, 32'h4);
    chk("t4_instr", ifc.instr, 32'h0040_A113);

    // 5: reset mid-stream with a full buffer, then drain with fetch disabled
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("t5_rst_valid", 32'(ifc.instr_valid), 32'd0);
    chk("t5_rst_addr", ifc.addr_bus, 32'h0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t5_full_addr", ifc.addr_bus, 32'h8);
    cyc(0, 0, 1, 0, 0);
    chk("t5_drain_pc", ifc.instr_pc, 32'h4);
    chk("t5_drain_addr", ifc.addr_bus, 32'h8);
    cyc(0, 0, 1, 0, 0);
    chk("t5_drained", 32'(ifc.instr_valid), 32'd0);
    chk("t5_frozen_addr", ifc.addr_bus, 32'h8);

    // PC wrap at the top of the address space
    cyc(0, 1, 1, 1, 32'hFFFF_FFFC);
    chk("wrap_addr_top", ifc.addr_bus, 32'hFFFF_FFFC);
    cyc(0, 1, 1, 0, 0);
    chk("wrap_head_pc", ifc.instr_pc, 32'hFFFF_FFFC);
    chk("wrap_addr_zero", ifc.addr_bus, 32'h0);
    cyc(0, 1, 1, 0, 0);
    chk("wrap_next_pc", ifc.instr_pc, 32'h0);
    chk("wrap_next_instr", ifc.instr, 32'h0030_6093);

    // 6: random traffic against the reference model
    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      fe = ($urandom_range(0, 7) != 0);
      rd = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 19) == 0);
      rp = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cyc(r, fe, rd, rv, rp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
